// File: rtl/motor_pkg.sv
// Shared motor-control definitions: direction codes, capture FSM states, duty saturation.
// Used by both the PWM generator and the PWM capture block.
package motor_pkg;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_FAULT = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_MEASURE = 1'b0;
  localparam state_t ST_REPORT  = 1'b1;

  function automatic logic [7:0] sat8(input logic [8:0] cnt);
    return cnt[8] ? 8'hff : cnt[7:0];
  endfunction

endpackage

// File: rtl/pwm_line_filter.sv
// 2-flop synchronizer for one async PWM line, 2 CLK latency; no backpressure.
// With PWM_CAPTURE_GLITCH_FILTER_EN, output follows only 3 equal samples in a row (+2 CLK).
module pwm_line_filter (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic clean
);

  logic s1, s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic d1, d2, held;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d1   <= 1'b0;
      d2   <= 1'b0;
      held <= 1'b0;
    end else begin
      d1   <= s2;
      d2   <= d1;
      held <= clean;
    end
  end

  // Combinational output keeps the added latency at exactly two samples.
  always_comb begin
    clean = held;
    if (s2 == d1 && d1 == d2) clean = s2;
  end
`else
  assign clean = s2;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures forward/reverse PWM duty per WIN_TICKS-tick window; report 1 CLK after window end.
// No backpressure: valid is a 1-cycle pulse. Optional PWM_CAPTURE_GLITCH_FILTER_EN in line filter.
module pwm_capture
  import motor_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int WIN_TICKS = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       pwm1,
  input  logic       pwm2,
  output logic [7:0] speed,
  output logic [1:0] dir,
  output logic       valid,
  output logic       fault
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(WIN_TICKS + 1);

  logic          line1, line2;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [8:0]    hi1, hi2;
  state_t        state;
  logic [1:0]    dir_n;
  logic [7:0]    speed_n;

  pwm_line_filter u_filt1 (.CLK(CLK), .RST(RST), .raw(pwm1), .clean(line1));
  pwm_line_filter u_filt2 (.CLK(CLK), .RST(RST), .raw(pwm2), .clean(line2));

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (RST)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  always_comb begin
    dir_n = {hi2 != 9'd0, hi1 != 9'd0};
    case (dir_n)
      DIR_FWD: speed_n = sat8(hi1);
      DIR_REV: speed_n = sat8(hi2);
      default: speed_n = 8'd0;
    endcase
  end

  // Ticks landing in the REPORT cycle are dropped; the prescaler keeps running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_MEASURE;
      tick_cnt <= '0;
      hi1      <= '0;
      hi2      <= '0;
      speed    <= '0;
      dir      <= DIR_STOP;
      valid    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == ST_MEASURE) begin
        if (tick) begin
          if (line1 && hi1 != 9'h1ff) hi1 <= hi1 + 9'd1;
          if (line2 && hi2 != 9'h1ff) hi2 <= hi2 + 9'd1;
          if (tick_cnt == TW'(WIN_TICKS - 1)) state <= ST_REPORT;
          else                                tick_cnt <= tick_cnt + 1'b1;
        end
      end else begin
        speed    <= speed_n;
        dir      <= dir_n;
        fault    <= (dir_n == DIR_FAULT);
        valid    <= 1'b1;
        hi1      <= '0;
        hi2      <= '0;
        tick_cnt <= '0;
        state    <= ST_MEASURE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture at PRESCALE=1, checked against a window-sum model.
module tb_pwm_capture;

  localparam int WIN    = 256;
  localparam int PERIOD = WIN + 1;
  localparam int HN     = 16384;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       pwm1 = 1'b0;
  logic       pwm2 = 1'b0;
  logic [7:0] speed;
  logic [1:0] dir;
  logic       valid;
  logic       fault;

  pwm_capture #(.PRESCALE(1), .WIN_TICKS(WIN)) dut (
    .CLK(CLK), .RST(RST), .pwm1(pwm1), .pwm2(pwm2),
    .speed(speed), .dir(dir), .valid(valid), .fault(fault)
  );

  always #5 CLK = ~CLK;

  bit         h1[HN];
  bit         h2[HN];
  int         edge_n   = 0;
  int         rel_edge = 0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  logic [7:0] last_speed = 8'd0;
  logic [1:0] last_dir   = 2'b00;
  logic       last_fault = 1'b0;

  // Line values as seen at each clock edge; reset edges read as 0.
  task automatic step(input logic p1, input logic p2);
    pwm1 = p1;
    pwm2 = p2;
    @(posedge CLK);
    if (edge_n < HN) begin
      h1[edge_n] = RST ? 1'b0 : p1;
      h2[edge_n] = RST ? 1'b0 : p2;
    end
    edge_n++;
    #1;
  endtask

  function automatic bit raw(input int line, input int idx);
    if (idx < 0 || idx >= HN) return 1'b0;
    return (line != 0) ? h2[idx] : h1[idx];
  endfunction

  // Value of a line that counts at edge j: input two edges earlier, optionally debounced.
  function automatic bit samp(input int line, input int j);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    for (int m = j; m >= 4; m--)
      if (raw(line, m-2) == raw(line, m-3) && raw(line, m-3) == raw(line, m-4))
        return raw(line, m-2);
    return 1'b0;
`else
    return raw(line, j-2);
`endif
  endfunction

  // kind 0: low, 1: high, 2: high for b of every a cycles, 3: random with density a/256.
  function automatic logic gen(input int kind, input int a, input int b, input int n);
    case (kind)
      0: return 1'b0;
      1: return 1'b1;
      2: return ((n % a) < b);
      default: return ($urandom_range(0, 255) < a);
    endcase
  endfunction

  task automatic run(input int k1, input int a1, input int b1,
                     input int k2, input int a2, input int b2,
                     input int nrep, input string tag);
    int seen, e, c1, c2;
    bit exp_v;
    logic [1:0] ed;
    logic [7:0] es;
    logic ef;
    seen = 0;
    while (seen < nrep) begin
      step(gen(k1, a1, b1, edge_n), gen(k2, a2, b2, edge_n));
      e = edge_n - 1;
      exp_v = (e >= rel_edge) && ((e - rel_edge) % PERIOD == WIN);
      if (exp_v || valid) begin
        n_cmp++;
        if (valid !== exp_v) begin
          n_bad++;
          $display("FAIL %s valid at edge %0d: got %b want %b", tag, e, valid, exp_v);
        end
      end
      if (e >= rel_edge && (e - rel_edge) % PERIOD == WIN - 1) begin
        n_cmp++;
        if ({speed, dir, fault} !== {last_speed, last_dir, last_fault}) begin
          n_bad++;
          $display("FAIL %s hold at edge %0d: got %0d/%b/%b want %0d/%b/%b",
                   tag, e, speed, dir, fault, last_speed, last_dir, last_fault);
        end
      end
      if (exp_v) begin
        c1 = 0;
        c2 = 0;
        for (int j = e - WIN; j < e; j++) begin
          c1 += int'(samp(0, j));
          c2 += int'(samp(1, j));
        end
        ed = {c2 != 0, c1 != 0};
        es = (ed == 2'b01) ? 8'((c1 > 255) ? 255 : c1) :
             (ed == 2'b10) ? 8'((c2 > 255) ? 255 : c2) : 8'd0;
        ef = (ed == 2'b11);
        n_cmp += 3;
        if (speed !== es) begin
          n_bad++;
          $display("FAIL %s speed at edge %0d: got %0d want %0d", tag, e, speed, es);
        end
        if (dir !== ed) begin
          n_bad++;
          $display("FAIL %s dir at edge %0d: got %b want %b", tag, e, dir, ed);
        end
        if (fault !== ef) begin
          n_bad++;
          $display("FAIL %s fault at edge %0d: got %b want %b", tag, e, fault, ef);
        end
        last_speed = es;
        last_dir   = ed;
        last_fault = ef;
        seen++;
      end
    end
  endtask

  task automatic apply_reset(input int ncyc);
    RST = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if ({speed, dir, valid, fault} !== 12'd0) begin
        n_bad++;
        $display("FAIL reset outputs cycle %0d: got %0d/%b/%b/%b want 0/00/0/0",
                 i, speed, dir, valid, fault);
      end
    end
    RST = 1'b0;
    rel_edge   = edge_n;
    last_speed = 8'd0;
    last_dir   = 2'b00;
    last_fault = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(5);
  endtask

  task automatic test_duty64;
    run(2, 256, 64, 0, 1, 0, 3, "duty64");
  endtask

  task automatic test_saturate;
    run(1, 1, 0, 0, 1, 0, 2, "saturate");
  endtask

  task automatic test_stop_then_rev;
    run(0, 1, 0, 0, 1, 0, 2, "stop");
    run(0, 1, 0, 2, 256, 128, 2, "rev128");
  endtask

  task automatic test_fault;
    run(2, 2, 1, 2, 4, 2, 2, "fault");
    run(2, 256, 64, 0, 1, 0, 2, "fault_clear");
  endtask

  task automatic test_glitch;
    run(2, 10, 1, 0, 1, 0, 3, "glitch");
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) begin
      int d1, d2;
      d1 = int'($urandom_range(0, 255));
      d2 = (r % 2 == 0) ? 0 : int'($urandom_range(0, 40));
      run(3, d1, 0, 3, d2, 0, 1, "random");
    end
  endtask

  task automatic test_reset_midwindow;
    int cnt;
    logic [7:0] want;
    while ((edge_n - 1 - rel_edge) % PERIOD != 99) step(1'b1, 1'b0);
    apply_reset(4);
    cnt = 0;
    while (valid !== 1'b1 && cnt < 400) begin
      step(1'b1, 1'b0);
      cnt++;
    end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    want = 8'd252;
`else
    want = 8'd254;
`endif
    n_cmp += 3;
    if (cnt != PERIOD) begin
      n_bad++;
      $display("FAIL rst_mid latency: got %0d cycles want %0d", cnt, PERIOD);
    end
    if (speed !== want) begin
      n_bad++;
      $display("FAIL rst_mid speed: got %0d want %0d", speed, want);
    end
    if (dir !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_mid dir: got %b want 01", dir);
    end
    last_speed = want;
    last_dir   = 2'b01;
    last_fault = 1'b0;
    run(2, 256, 64, 0, 1, 0, 1, "post_rst");
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_saturate();
    test_stop_then_rev();
    test_fault();
    test_glitch();
    test_random();
    test_reset_midwindow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
